// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests over a
// req/gnt/rvalid memory port, buffers returned words with their PCs and
// presents the FIFO head to the IF/ID register. A redirect flushes the buffer
// and marks every in-flight response as stale so it is dropped on arrival.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus_4F,
  output logic        validF
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0]   occupancy;
  logic          accept;
  logic          resp_push;
  logic          pop;
  logic [31:0]   resp_pc;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Request issue and response bookkeeping; responses always have a slot
  // because buffered plus outstanding never exceeds DEPTH.
  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, outst_q};
    imem_req  = !reset && !redirect && (occupancy < DEPTH_OCC);
    imem_addr = fetch_pc_q;
    accept    = imem_req && imem_gnt;
    resp_push = imem_rvalid && (drop_q == '0) && !redirect;
    pop       = validF && !stallF && !redirect;
    // Once all stale responses are gone, every outstanding request is live,
    // so the oldest one sits outst_q words behind the fetch PC.
    resp_pc   = fetch_pc_q - ({{(32-CW){1'b0}}, outst_q} << 2);
  end

  // Next-state for PC, pointers and counters; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(imem_rvalid);
      drop_d     = outst_q - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(accept) - CW'(imem_rvalid);
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (resp_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(resp_push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Buffer storage; contents only matter where count marks them valid.
  always_ff @(posedge clk) begin
    if (!reset && resp_push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc;
    end
  end

  // Decode-side view of the buffer head, NOP when empty.
  always_comb begin
    validF     = (count_q != '0);
    instrF     = validF ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    pcF        = validF ? pc_mem_q[rd_ptr_q] : 32'h0;
    pc_plus_4F = pcF + 32'd4;
  end

endmodule
